// File: rtl/nn_layer_engine.sv
// Fully connected layer engine: LANES parallel saturating fixed-point MAC lanes,
// streamed input vector, per-neuron bias and activation, tiled serial output stream.
module nn_layer_engine #(
  parameter int LANES   = 4,
  parameter int Q_INT   = 8,
  parameter int Q_FRAC  = 8,
  parameter int X_DEPTH = 64,
  parameter int W_DEPTH = 256,
  parameter int OUT_MAX = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [$clog2(X_DEPTH):0]               cfg_in_len,
  input  logic [$clog2(OUT_MAX):0]               cfg_out_len,
  input  logic [1:0]                             cfg_act,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  input  logic                                   w_write_enable,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] w_lane,
  input  logic [$clog2(W_DEPTH)-1:0]             w_addr,
  input  logic                                   b_write_enable,
  input  logic [$clog2(OUT_MAX)-1:0]             b_addr,
  input  logic [Q_INT+Q_FRAC-1:0]                wb_data,
  input  logic                                   x_valid,
  output logic                                   x_ready,
  input  logic [Q_INT+Q_FRAC-1:0]                x_data,
  output logic                                   y_valid,
  input  logic                                   y_ready,
  output logic [Q_INT+Q_FRAC-1:0]                y_data,
  output logic                                   y_last
);

  localparam int Q_SIZE = Q_INT + Q_FRAC;
  localparam int XL_W   = $clog2(X_DEPTH) + 1;
  localparam int OL_W   = $clog2(OUT_MAX) + 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int XA_W   = $clog2(X_DEPTH);
  localparam int WA_W   = $clog2(W_DEPTH);
  localparam int BA_W   = $clog2(OUT_MAX);
  localparam int ACC_W  = 2 * Q_SIZE + $clog2(X_DEPTH);
  localparam int PROD_W = 2 * Q_SIZE;
  localparam int CW     = XL_W + OL_W + WA_W;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [ACC_W:0]    sum_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic        [CW-1:0]     count_t;
  typedef logic        [Q_SIZE-1:0] word_t;

  localparam word_t Q_MAX = {1'b0, {(Q_SIZE-1){1'b1}}};
  localparam word_t Q_MIN = {1'b1, {(Q_SIZE-1){1'b0}}};
  localparam word_t Q_ONE = word_t'(1) << Q_FRAC;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_BIAS, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [XL_W-1:0]   in_len_q, cnt_q;
  logic [OL_W-1:0]   out_len_q;
  logic [1:0]        act_q;
  logic              error_q, done_q, rd_valid_q;
  count_t            w_base_q, n_base_q;
  logic [LANE_W-1:0] drain_idx_q;
  acc_t              acc_q   [LANES];
  word_t             y_reg_q [LANES];

  word_t x_mem [X_DEPTH];
  word_t w_mem [LANES][W_DEPTH];
  word_t b_mem [OUT_MAX];
  word_t x_rd_q;
  word_t w_rd_q [LANES];
  word_t b_rd_q [LANES];
  prod_t prod   [LANES];

  // Rounds toward -inf by arithmetic shift, saturates, then applies the activation.
  function automatic word_t finish_neuron(input acc_t acc, input word_t bias, input logic [1:0] act);
    sum_t  sum, shifted;
    word_t sat, res;
    sum     = sum_t'(acc) + (sum_t'($signed(bias)) <<< Q_FRAC);
    shifted = sum >>> Q_FRAC;
    if (shifted > sum_t'($signed(Q_MAX)))      sat = Q_MAX;
    else if (shifted < sum_t'($signed(Q_MIN))) sat = Q_MIN;
    else                                       sat = shifted[Q_SIZE-1:0];
    res = sat;
    case (act)
      2'd1:    if ($signed(sat) < 0) res = '0;
      2'd2: begin
        if ($signed(sat) < 0)                 res = '0;
        else if ($signed(sat) > $signed(Q_ONE)) res = Q_ONE;
      end
      default: res = sat;
    endcase
    return res;
  endfunction

  // Start-time shape check: P = ceil(out_len/LANES) passes of in_len weights each.
  count_t passes_req, words_req;
  logic   cfg_ok;
  always_comb begin
    passes_req = (count_t'(cfg_out_len) + count_t'(LANES - 1)) / count_t'(LANES);
    words_req  = passes_req * count_t'(cfg_in_len);
    cfg_ok     = (cfg_in_len != '0) && (count_t'(cfg_in_len) <= count_t'(X_DEPTH)) &&
                 (cfg_out_len != '0) && (count_t'(cfg_out_len) <= count_t'(OUT_MAX)) &&
                 (words_req <= count_t'(W_DEPTH));
  end

  count_t remaining;
  logic   pass_end, layer_end;
  always_comb begin
    remaining = count_t'(out_len_q) - n_base_q;
    pass_end  = (drain_idx_q == LANE_W'(LANES - 1)) ||
                (count_t'(drain_idx_q) + count_t'(1) == remaining);
    layer_end = (n_base_q + count_t'(LANES)) >= count_t'(out_len_q);
    for (int l = 0; l < LANES; l++)
      prod[l] = prod_t'($signed(x_rd_q)) * prod_t'($signed(w_rd_q[l]));
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && cfg_ok) state_d = S_LOAD;
      S_LOAD:  if (x_valid && (cnt_q == in_len_q - XL_W'(1))) state_d = S_MAC;
      S_MAC:   if (cnt_q == in_len_q) state_d = S_BIAS;
      S_BIAS:  state_d = S_DRAIN;
      S_DRAIN: if (y_ready && pass_end) state_d = layer_end ? S_IDLE : S_MAC;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_len_q    <= '0;
      out_len_q   <= '0;
      act_q       <= '0;
      cnt_q       <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      w_base_q    <= '0;
      n_base_q    <= '0;
      drain_idx_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l]   <= '0;
        y_reg_q[l] <= '0;
      end
    end else begin
      state_q    <= state_d;
      done_q     <= 1'b0;
      rd_valid_q <= (state_q == S_MAC) && (cnt_q < in_len_q);
      case (state_q)
        S_IDLE: if (start) begin
          if (cfg_ok) begin
            error_q     <= 1'b0;
            in_len_q    <= cfg_in_len;
            out_len_q   <= cfg_out_len;
            act_q       <= cfg_act;
            cnt_q       <= '0;
            w_base_q    <= '0;
            n_base_q    <= '0;
            drain_idx_q <= '0;
          end else begin
            error_q <= 1'b1;
          end
        end
        S_LOAD: if (x_valid) cnt_q <= (cnt_q == in_len_q - XL_W'(1)) ? '0 : cnt_q + XL_W'(1);
        S_MAC:  cnt_q <= (cnt_q == in_len_q) ? '0 : cnt_q + XL_W'(1);
        S_BIAS: begin
          drain_idx_q <= '0;
          for (int l = 0; l < LANES; l++)
            y_reg_q[l] <= finish_neuron(acc_q[l], b_rd_q[l], act_q);
        end
        S_DRAIN: if (y_ready) begin
          if (pass_end) begin
            drain_idx_q <= '0;
            if (layer_end) begin
              done_q <= 1'b1;
            end else begin
              n_base_q <= n_base_q + count_t'(LANES);
              w_base_q <= w_base_q + count_t'(in_len_q);
            end
          end else begin
            drain_idx_q <= drain_idx_q + LANE_W'(1);
          end
        end
        default: ;
      endcase
      // Cycle 0 of each pass has no read data yet, so it clears the accumulators.
      for (int l = 0; l < LANES; l++) begin
        if (state_q == S_MAC && cnt_q == '0) acc_q[l] <= '0;
        else if (rd_valid_q)                 acc_q[l] <= acc_q[l] + acc_t'(prod[l]);
      end
    end
  end

  // NOTE: memories carry no reset; their contents survive reset and only the write ports change them.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && x_valid) x_mem[cnt_q[XA_W-1:0]] <= x_data;
    if (state_q == S_IDLE && w_write_enable && (count_t'(w_lane) < count_t'(LANES)))
      w_mem[w_lane][w_addr] <= wb_data;
    if (state_q == S_IDLE && b_write_enable) b_mem[b_addr] <= wb_data;
    x_rd_q <= x_mem[cnt_q[XA_W-1:0]];
    for (int l = 0; l < LANES; l++) begin
      w_rd_q[l] <= w_mem[l][WA_W'(w_base_q + count_t'(cnt_q))];
      b_rd_q[l] <= b_mem[BA_W'(n_base_q + count_t'(l))];
    end
  end

  always_comb begin
    y_data = '0;
    if (state_q == S_DRAIN) y_data = y_reg_q[drain_idx_q];
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign error   = error_q;
  assign x_ready = (state_q == S_LOAD);
  assign y_valid = (state_q == S_DRAIN);
  assign y_last  = (state_q == S_DRAIN) &&
                   (n_base_q + count_t'(drain_idx_q) + count_t'(1) == count_t'(out_len_q));

endmodule
